// File: rtl/lsu_stage_if.sv
// Bundle of the three LSU handshakes: EXU->LSU payload, data-memory port,
// and LSU->WBU payload. The slave modport is the LSU's own view; the
// master modport is the surrounding pipeline/memory/WBU view.
interface lsu_stage_if;
  // EXU -> LSU
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc_target;
  logic [31:0] in_exu_result;
  logic [31:0] in_mem_addr;
  logic [31:0] in_mem_wdata;
  logic        in_reg_wen;
  logic        in_mem_en;
  logic        in_mem_wen;
  logic [4:0]  in_rd_addr;
  logic [2:0]  in_funct3;
  // LSU <-> data memory
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  // LSU -> WBU
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc_target;
  logic [31:0] out_wb_data;
  logic        out_reg_wen;
  logic [4:0]  out_rd_addr;
  logic        out_fault;

  modport master (
    output in_valid, in_pc_target, in_exu_result, in_mem_addr, in_mem_wdata,
           in_reg_wen, in_mem_en, in_mem_wen, in_rd_addr, in_funct3,
    input  in_ready,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  out_valid, out_pc_target, out_wb_data, out_reg_wen, out_rd_addr, out_fault,
    output out_ready
  );

  modport slave (
    input  in_valid, in_pc_target, in_exu_result, in_mem_addr, in_mem_wdata,
           in_reg_wen, in_mem_en, in_mem_wen, in_rd_addr, in_funct3,
    output in_ready,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output out_valid, out_pc_target, out_wb_data, out_reg_wen, out_rd_addr, out_fault,
    input  out_ready
  );
endinterface

// File: rtl/lsu_stage.sv
// Memory-access stage: single-entry buffer between EXU and WBU that performs
// one load/store on a request/response data-memory port with a response
// timeout. Handshake flags are registered copies of the next FSM state.
module lsu_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic         clk,
  input logic         rst,
  lsu_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  // funct3[1:0] picks the size; 11 and the undefined codes fall back to word.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3[1:0])
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      default: bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] strb;
    case (f3[1:0])
      2'b00:   strb = 4'b0001 << off;
      2'b01:   strb = 4'b0011 << off;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  v = {{24{b[7]}}, b};
      3'b001:  v = {{16{h[15]}}, h};
      3'b100:  v = {24'd0, b};
      3'b101:  v = {16'd0, h};
      default: v = rd;
    endcase
    return v;
  endfunction

  state_t      state_r, state_nx_s;
  logic        in_ready_r, req_valid_r, out_valid_r;
  logic [31:0] pc_target_r, exu_result_r, addr_r, wdata_r, wb_data_r;
  logic        reg_wen_r, mem_en_r, mem_wen_r, fault_r;
  logic [4:0]  rd_addr_r;
  logic [2:0]  funct3_r;
  logic [7:0]  tmo_cnt_r;
  logic        misalign_s, tmo_hit_s;

  assign misalign_s = misaligned(bus.in_funct3, bus.in_mem_addr[1:0]);
  assign tmo_hit_s  = (tmo_cnt_r == TMO_LAST);

  // Next-state logic of the access FSM.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!bus.in_valid)      state_nx_s = S_IDLE;
        else if (!bus.in_mem_en) state_nx_s = S_WB;
        else if (misalign_s)    state_nx_s = S_WB;
        else                    state_nx_s = S_REQ;
      end
      S_REQ: begin
        if (bus.mem_req_ready) state_nx_s = S_RESP;
        else                   state_nx_s = S_REQ;
      end
      S_RESP: begin
        if (bus.mem_resp_valid) state_nx_s = S_WB;
        else if (tmo_hit_s)     state_nx_s = S_WB;
        else                    state_nx_s = S_RESP;
      end
      S_WB: begin
        if (bus.out_ready) state_nx_s = S_IDLE;
        else               state_nx_s = S_WB;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register plus registered handshake flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      req_valid_r <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == S_IDLE);
      req_valid_r <= (state_nx_s == S_REQ);
      out_valid_r <= (state_nx_s == S_WB);
    end
  end

  // Payload latch, loaded only when a new payload is accepted in S_IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_target_r  <= 32'd0;
      exu_result_r <= 32'd0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      reg_wen_r    <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_wen_r    <= 1'b0;
      rd_addr_r    <= 5'd0;
      funct3_r     <= 3'd0;
    end else if ((state_r == S_IDLE) && bus.in_valid) begin
      pc_target_r  <= bus.in_pc_target;
      exu_result_r <= bus.in_exu_result;
      addr_r       <= bus.in_mem_addr;
      wdata_r      <= bus.in_mem_wdata;
      reg_wen_r    <= bus.in_reg_wen;
      mem_en_r     <= bus.in_mem_en;
      mem_wen_r    <= bus.in_mem_wen;
      rd_addr_r    <= bus.in_rd_addr;
      funct3_r     <= bus.in_funct3;
    end
  end

  // Write-back value, fault flag and response timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_r <= 32'd0;
      fault_r   <= 1'b0;
      tmo_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.in_valid) begin
            fault_r   <= bus.in_mem_en & misalign_s;
            wb_data_r <= (bus.in_mem_en & misalign_s) ? 32'd0 : bus.in_exu_result;
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) tmo_cnt_r <= 8'd0;
        end
        S_RESP: begin
          if (bus.mem_resp_valid) begin
            // A store completes with its response but writes back the EXU result.
            wb_data_r <= mem_wen_r ? exu_result_r
                                   : load_extract(funct3_r, addr_r[1:0], bus.mem_resp_rdata);
          end else if (tmo_hit_s) begin
            fault_r   <= 1'b1;
            wb_data_r <= 32'd0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        default: begin
          wb_data_r <= wb_data_r;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_r;
  assign bus.mem_req_valid = req_valid_r;
  assign bus.mem_req_addr  = {addr_r[31:2], 2'b00};
  assign bus.mem_req_wen   = mem_wen_r & mem_en_r;
  assign bus.mem_req_wdata = mem_wen_r ? store_data(funct3_r, wdata_r) : 32'd0;
  assign bus.mem_req_wstrb = mem_wen_r ? store_strb(funct3_r, addr_r[1:0]) : 4'b0000;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_pc_target = pc_target_r;
  assign bus.out_wb_data   = wb_data_r;
  assign bus.out_reg_wen   = reg_wen_r & ~fault_r;
  assign bus.out_rd_addr   = rd_addr_r;
  assign bus.out_fault     = fault_r;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: ALU pass-through, loads, stores with request
// backpressure, misalignment, response timeout, WBU backpressure and reset.
module tb_lsu_stage;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  lsu_stage_if bus ();

  lsu_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_payload(input logic [31:0] pc, input logic [31:0] exu,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic rwen, input logic men, input logic mwen,
                               input logic [4:0] rd, input logic [2:0] f3);
    bus.in_valid      = 1'b1;
    bus.in_pc_target  = pc;
    bus.in_exu_result = exu;
    bus.in_mem_addr   = addr;
    bus.in_mem_wdata  = wdata;
    bus.in_reg_wen    = rwen;
    bus.in_mem_en     = men;
    bus.in_mem_wen    = mwen;
    bus.in_rd_addr    = rd;
    bus.in_funct3     = f3;
  endtask

  // One memory access; req_wait cycles of mem_req_ready=0 before the request is taken.
  task automatic mem_op(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic mwen, input logic [2:0] f3, input logic rwen,
                        input logic [31:0] exu, input int req_wait, input logic [31:0] rdata,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_wb, input logic exp_rwen);
    @(negedge clk);
    check_eq({tag, "_in_ready"}, bus.in_ready, 32'd1);
    drive_payload(32'h0000_0100, exu, addr, wdata, rwen, 1'b1, mwen, 5'd7, f3);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i <= req_wait; i++) begin
      check_eq({tag, "_req_valid"}, bus.mem_req_valid, 32'd1);
      check_eq({tag, "_req_addr"},  bus.mem_req_addr, {addr[31:2], 2'b00});
      check_eq({tag, "_req_wen"},   bus.mem_req_wen, {31'd0, mwen});
      check_eq({tag, "_req_wstrb"}, bus.mem_req_wstrb, {28'd0, exp_strb});
      if (mwen) check_eq({tag, "_req_wdata"}, bus.mem_req_wdata, exp_wdata);
      check_eq({tag, "_busy_in_ready"}, bus.in_ready, 32'd0);
      bus.mem_req_ready = (i == req_wait);
      if (i < req_wait) @(negedge clk);
    end
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check_eq({tag, "_resp_req_valid"}, bus.mem_req_valid, 32'd0);
    check_eq({tag, "_resp_out_valid"}, bus.out_valid, 32'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = rdata;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 32'd0;
    check_eq({tag, "_out_valid"}, bus.out_valid, 32'd1);
    check_eq({tag, "_wb_data"},   bus.out_wb_data, exp_wb);
    check_eq({tag, "_reg_wen"},   bus.out_reg_wen, {31'd0, exp_rwen});
    check_eq({tag, "_fault"},     bus.out_fault, 32'd0);
    check_eq({tag, "_rd"},        bus.out_rd_addr, 32'd7);
  endtask

  initial begin
    int cnt;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive_payload(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0);
    bus.in_valid       = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 32'd0;
    bus.out_ready      = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Reset state, plus a spurious response in S_IDLE that must be ignored.
    bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check_eq("rst_in_ready",  bus.in_ready, 32'd1);
    check_eq("rst_out_valid", bus.out_valid, 32'd0);
    check_eq("rst_req_valid", bus.mem_req_valid, 32'd0);
    check_eq("rst_wb_data",   bus.out_wb_data, 32'd0);
    check_eq("rst_fault",     bus.out_fault, 32'd0);

    // ALU op: out_valid one cycle after accept, no memory request.
    drive_payload(32'h0000_2000, 32'h0000_1234, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd5, 3'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("alu_out_valid", bus.out_valid, 32'd1);
    check_eq("alu_wb_data",   bus.out_wb_data, 32'h0000_1234);
    check_eq("alu_rd",        bus.out_rd_addr, 32'd5);
    check_eq("alu_reg_wen",   bus.out_reg_wen, 32'd1);
    check_eq("alu_pc",        bus.out_pc_target, 32'h0000_2000);
    check_eq("alu_req_valid", bus.mem_req_valid, 32'd0);
    @(negedge clk);
    check_eq("alu_done_out_valid", bus.out_valid, 32'd0);

    // Loads and a store with a stalled request.
    mem_op("lb",  32'h8000_0003, 32'h0, 1'b0, 3'b000, 1'b1, 32'h0, 0, 32'h80FF_0000,
           4'b0000, 32'h0, 32'hFFFF_FF80, 1'b1);
    mem_op("lhu", 32'h8000_0002, 32'h0, 1'b0, 3'b101, 1'b1, 32'h0, 0, 32'hBEEF_0000,
           4'b0000, 32'h0, 32'h0000_BEEF, 1'b1);
    mem_op("lh",  32'h8000_0000, 32'h0, 1'b0, 3'b001, 1'b1, 32'h0, 1, 32'h1234_8001,
           4'b0000, 32'h0, 32'hFFFF_8001, 1'b1);
    mem_op("sb",  32'h8000_0001, 32'h0000_00AB, 1'b1, 3'b000, 1'b0, 32'h0000_0011, 3,
           32'hDEAD_BEEF, 4'b0010, 32'hABAB_ABAB, 32'h0000_0011, 1'b0);
    mem_op("sh",  32'h8000_0006, 32'h0000_CAFE, 1'b1, 3'b001, 1'b0, 32'h0000_0022, 0,
           32'h0, 4'b1100, 32'hCAFE_CAFE, 32'h0000_0022, 1'b0);

    // Misaligned LW: no request, fault, no register write.
    @(negedge clk);
    drive_payload(32'h0000_3000, 32'h5555_5555, 32'h8000_0002, 32'h0, 1'b1, 1'b1, 1'b0, 5'd9, 3'b010);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("mis_req_valid", bus.mem_req_valid, 32'd0);
    check_eq("mis_out_valid", bus.out_valid, 32'd1);
    check_eq("mis_fault",     bus.out_fault, 32'd1);
    check_eq("mis_reg_wen",   bus.out_reg_wen, 32'd0);
    check_eq("mis_wb_data",   bus.out_wb_data, 32'd0);

    // Timeout: aligned LW, request taken, never answered.
    @(negedge clk);
    drive_payload(32'h0000_4000, 32'h6666_6666, 32'h8000_0004, 32'h0, 1'b1, 1'b1, 1'b0, 5'd3, 3'b010);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("tmo_req_valid", bus.mem_req_valid, 32'd1);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) break;
      cnt++;
      @(negedge clk);
    end
    check_eq("tmo_resp_cycles", cnt, 32'd4);
    check_eq("tmo_out_valid",   bus.out_valid, 32'd1);
    check_eq("tmo_fault",       bus.out_fault, 32'd1);
    check_eq("tmo_reg_wen",     bus.out_reg_wen, 32'd0);
    check_eq("tmo_wb_data",     bus.out_wb_data, 32'd0);

    // WBU backpressure, with a second payload offered that must not be taken.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_payload(32'h0000_5000, 32'h0000_ABCD, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd12, 3'd0);
    @(negedge clk);
    drive_payload(32'h0000_6000, 32'h0000_9999, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd13, 3'd0);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_out_valid", bus.out_valid, 32'd1);
      check_eq("bp_wb_data",   bus.out_wb_data, 32'h0000_ABCD);
      check_eq("bp_rd",        bus.out_rd_addr, 32'd12);
      check_eq("bp_pc",        bus.out_pc_target, 32'h0000_5000);
      check_eq("bp_in_ready",  bus.in_ready, 32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    check_eq("bp_rst_out_valid", bus.out_valid, 32'd0);
    check_eq("bp_rst_in_ready",  bus.in_ready, 32'd1);
    check_eq("bp_rst_wb_data",   bus.out_wb_data, 32'd0);

    // Reset mid-access, then a late response that S_IDLE must ignore.
    drive_payload(32'h0000_7000, 32'h0, 32'h8000_0008, 32'h0, 1'b1, 1'b1, 1'b0, 5'd4, 3'b010);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h1357_9BDF;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check_eq("late_out_valid", bus.out_valid, 32'd0);
    check_eq("late_in_ready",  bus.in_ready, 32'd1);
    check_eq("late_req_valid", bus.mem_req_valid, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
